legv8_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the LEGv8 byte-wide instruction memory.
//  - Walks the PC and issues four byte reads per instruction to a single-ported, 1-cycle-latency byte memory.
//  - Assembles the bytes big-endian into a 32-bit instruction: byte at PC -> inst[31:24].
//  - Hands the instruction to decode on a valid/ready handshake.
//  - Sits between the PC/branch logic and the instruction memory; accepts branch redirects with flush.

---
 rtl/legv8_fetch_ctrl_if.sv | 30 +++
 rtl/legv8_fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_legv8_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/legv8_fetch_ctrl_if.sv
// Fetch-controller bus bundle: redirect input, byte-memory port and decode handshake.
// Latency: none (wiring only).
// Backpressure: inst_ready from decode stalls the presented instruction.
//
// master : fetch controller side (drives memory strobe/address and instruction outputs)
// slave  : environment side (branch logic, byte memory, decode)
interface legv8_fetch_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              redirect_valid;
   logic [63:0]       redirect_pc;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [63:0]       inst_pc;
   logic              fetch_fault;

   modport master (
      input  redirect_valid, redirect_pc, mem_rdata, inst_ready,
      output mem_rd_en, mem_addr, inst_valid, inst, inst_pc, fetch_fault
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_rdata, inst_ready,
      input  mem_rd_en, mem_addr, inst_valid, inst, inst_pc, fetch_fault
   );
endinterface

// File: rtl/legv8_fetch_ctrl.sv
// Fetch sequencer: four byte reads per instruction, assembled big-endian, handed to decode.
// Latency: first read at cycle 0, inst_valid at cycle 5; one instruction per 6 cycles at full rate.
// Backpressure: inst_valid holds inst/inst_pc stable until inst_ready; no reads issued while stalled.
//
// Ports: clk, rst (async, active high), bus (legv8_fetch_ctrl_if.master):
//   redirect_valid/redirect_pc  branch/exception restart, flushes the fetch in flight
//   mem_rd_en/mem_addr/mem_rdata  single-ported byte memory, 1-cycle read latency
//   inst_valid/inst_ready/inst/inst_pc  instruction handoff to decode
//   fetch_fault  misaligned-PC indication (only with FETCH_ALIGN_CHECK_EN defined)
// Optional feature macro: FETCH_ALIGN_CHECK_EN enables the PC alignment check and FAULT state.
module legv8_fetch_ctrl #(
   parameter int          ADDR_W   = 8,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input logic                clk,
   input logic                rst,
   legv8_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DRAIN = 2'd1,
      S_VALID = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
      , S_FAULT = 2'd3
`endif
   } state_t;

   state_t            state, state_nxt;
   logic [63:0]       pc;
   logic [63:0]       inst_pc_q;
   logic [31:0]       inst_q;
   logic [1:0]        byte_cnt;
   logic              handshake;
   logic              misaligned;
   logic              cap_en;
   logic [1:0]        cap_lane;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic              valid;
   logic              fault;

   assign handshake = (state == S_VALID) && bus.inst_ready;

   // Alignment is only judged before the first byte of an instruction is read.
`ifdef FETCH_ALIGN_CHECK_EN
   assign misaligned = (state == S_FETCH) && (byte_cnt == 2'd0) && (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; redirect overrides everything, including a same-cycle handshake.
   always_comb begin
      state_nxt = state;
      if (bus.redirect_valid) begin
         state_nxt = S_FETCH;
      end else begin
         case (state)
            S_FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (misaligned) state_nxt = S_FAULT;
               else
`endif
               if (byte_cnt == 2'd3) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_VALID;
            S_VALID: if (bus.inst_ready) state_nxt = S_FETCH;
            default: state_nxt = state;   // FAULT waits for a redirect
         endcase
      end
   end

   // Output logic; reads are suppressed while reset is held since state already shows FETCH.
   always_comb begin
      rd_en = 1'b0;
      addr  = '0;
      valid = 1'b0;
      fault = 1'b0;
      case (state)
         S_FETCH: begin
            rd_en = !misaligned && !rst;
            if (rd_en) addr = pc[ADDR_W-1:0] + ADDR_W'(byte_cnt);
         end
         S_VALID: valid = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
         S_FAULT: fault = 1'b1;
`endif
         default: ;
      endcase
   end

   // Read data lands one cycle after its strobe. A redirect resets byte_cnt to 0, so the
   // byte returning right after a redirect is never captured.
   always_comb begin
      cap_en   = 1'b0;
      cap_lane = 2'd0;
      if ((state == S_FETCH) && (byte_cnt != 2'd0)) begin
         cap_en   = 1'b1;
         cap_lane = byte_cnt - 2'd1;
      end else if (state == S_DRAIN) begin
         cap_en   = 1'b1;
         cap_lane = 2'd3;
      end
   end

   // Datapath: PC, byte counter, instruction assembly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_PC;
         byte_cnt  <= 2'd0;
         inst_q    <= 32'd0;
         inst_pc_q <= 64'd0;
      end else begin
         if (cap_en) begin
            case (cap_lane)
               2'd0:    inst_q[31:24] <= bus.mem_rdata;
               2'd1:    inst_q[23:16] <= bus.mem_rdata;
               2'd2:    inst_q[15:8]  <= bus.mem_rdata;
               default: inst_q[7:0]   <= bus.mem_rdata;
            endcase
         end
         if (state == S_DRAIN) inst_pc_q <= pc;

         if (bus.redirect_valid) begin
            pc       <= bus.redirect_pc;
            byte_cnt <= 2'd0;
         end else if (handshake) begin
            pc       <= pc + 64'd4;
            byte_cnt <= 2'd0;
         end else if ((state == S_FETCH) && !misaligned) begin
            byte_cnt <= byte_cnt + 2'd1;   // 3 -> 0 as the FSM moves to DRAIN
         end
      end
   end

   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_addr    = addr;
   assign bus.inst_valid  = valid;
   assign bus.inst        = inst_q;
   assign bus.inst_pc     = inst_pc_q;
   assign bus.fetch_fault = fault;

endmodule

// File: tb/tb_legv8_fetch_ctrl.sv
module tb_legv8_fetch_ctrl;

   logic clk;
   logic rst;
   logic [7:0] mem [256];
   int vectors;
   int miscompares;

   legv8_fetch_ctrl_if #(.ADDR_W(8)) bus ();

   legv8_fetch_ctrl #(.ADDR_W(8), .RESET_PC(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory with one cycle of read latency
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Big-endian word at a byte address, wrapping in the 256-byte memory
   function automatic logic [31:0] word_at(input logic [63:0] a);
      logic [7:0] b0 = a[7:0];
      logic [7:0] b1 = b0 + 8'd1;
      logic [7:0] b2 = b0 + 8'd2;
      logic [7:0] b3 = b0 + 8'd3;
      return {mem[b0], mem[b1], mem[b2], mem[b3]};
   endfunction

   function automatic logic [63:0] pick_pc();
      logic [63:0] p;
      case ($urandom % 4)
         0:       p = {$urandom, $urandom};
         1:       p = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom % 8);
         2:       p = 64'($urandom % 256);
         default: p = 64'h0FC + 64'($urandom % 4);
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      p[1:0] = 2'b00;
`endif
      return p;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
      check({tag, "_addr"},  64'(bus.mem_addr), 64'd0);
      check({tag, "_valid"}, 64'(bus.inst_valid), 64'd0);
      check({tag, "_inst"},  64'(bus.inst), 64'd0);
      check({tag, "_pc"},    bus.inst_pc, 64'd0);
      check({tag, "_fault"}, 64'(bus.fetch_fault), 64'd0);
   endtask

   initial begin
      logic [63:0] exp_pc;
      int          age;
      logic [7:0]  ea;

      vectors = 0;
      miscompares = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h8B; mem[1] = 8'h1F; mem[2] = 8'h03; mem[3] = 8'hE0;
      mem[8'h20] = 8'hA5; mem[8'h21] = 8'h5A; mem[8'h22] = 8'hC3; mem[8'h23] = 8'h3C;

      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'd0;
      bus.inst_ready     = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");

      // 1: first fetch timing and big-endian assembly
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("t1_rd_en", 64'(bus.mem_rd_en), 64'd1);
         check("t1_addr", 64'(bus.mem_addr), 64'(k));
         check("t1_valid", 64'(bus.inst_valid), 64'd0);
         tick();
      end
      check("t1_drain_rd_en", 64'(bus.mem_rd_en), 64'd0);
      check("t1_drain_valid", 64'(bus.inst_valid), 64'd0);
      tick();
      check("t1_valid5", 64'(bus.inst_valid), 64'd1);
      check("t1_inst", 64'(bus.inst), 64'h8B1F03E0);
      check("t1_pc", bus.inst_pc, 64'd0);

      // 2: stall for 10 cycles, then release
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2_valid", 64'(bus.inst_valid), 64'd1);
         check("t2_rd_en", 64'(bus.mem_rd_en), 64'd0);
         check("t2_inst", 64'(bus.inst), 64'h8B1F03E0);
         check("t2_pc", bus.inst_pc, 64'd0);
      end
      bus.inst_ready = 1'b1;
      tick();
      check("t2_drop_valid", 64'(bus.inst_valid), 64'd0);
      check("t2_next_rd_en", 64'(bus.mem_rd_en), 64'd1);
      check("t2_next_addr", 64'(bus.mem_addr), 64'd4);

      // 3: redirect while the third byte is being read
      tick();
      tick();
      check("t3_addr6", 64'(bus.mem_addr), 64'd6);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h40;
      tick();
      bus.redirect_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("t3_valid", 64'(bus.inst_valid), 64'd0);
         if (k < 4) check("t3_addr", 64'(bus.mem_addr), 64'h40 + 64'(k));
         tick();
      end
      check("t3_valid5", 64'(bus.inst_valid), 64'd1);
      check("t3_pc", bus.inst_pc, 64'h40);
      check("t3_inst", 64'(bus.inst), 64'(word_at(64'h40)));

      // 4: handshake and redirect together
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h80;
      tick();
      bus.redirect_valid = 1'b0;
      check("t4_valid_drop", 64'(bus.inst_valid), 64'd0);
      check("t4_addr", 64'(bus.mem_addr), 64'h80);
      repeat (5) tick();
      check("t4_valid", 64'(bus.inst_valid), 64'd1);
      check("t4_pc", bus.inst_pc, 64'h80);
      check("t4_inst", 64'(bus.inst), 64'(word_at(64'h80)));

      // 5: address wrap at the top of the byte space / misaligned PC
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFE;
      tick();
      bus.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      check("t5_no_rd", 64'(bus.mem_rd_en), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_fault", 64'(bus.fetch_fault), 64'd1);
         check("t5_fault_rd_en", 64'(bus.mem_rd_en), 64'd0);
         check("t5_fault_valid", 64'(bus.inst_valid), 64'd0);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h10;
      tick();
      bus.redirect_valid = 1'b0;
      check("t5_fault_clear", 64'(bus.fetch_fault), 64'd0);
      check("t5_recover_addr", 64'(bus.mem_addr), 64'h10);
      check("t5_recover_rd_en", 64'(bus.mem_rd_en), 64'd1);
`else
      for (int k = 0; k < 4; k++) begin
         ea = 8'hFE + 8'(k);
         check("t5_rd_en", 64'(bus.mem_rd_en), 64'd1);
         check("t5_addr", 64'(bus.mem_addr), 64'(ea));
         tick();
      end
      tick();
      check("t5_valid", 64'(bus.inst_valid), 64'd1);
      check("t5_pc", bus.inst_pc, 64'hFE);
      check("t5_inst", 64'(bus.inst), 64'(word_at(64'hFE)));
      check("t5_fault", 64'(bus.fetch_fault), 64'd0);
`endif

      // 6: reset asserted during DRAIN
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h20;
      tick();
      bus.redirect_valid = 1'b0;
      repeat (4) tick();
      check("t6_drain_rd_en", 64'(bus.mem_rd_en), 64'd0);
      rst = 1'b1;
      #1;
      check_all_zero("t6_rst");
      tick();
      check("t6_rst_hold_rd_en", 64'(bus.mem_rd_en), 64'd0);
      rst = 1'b0;
      #1;
      check("t6_refetch_rd_en", 64'(bus.mem_rd_en), 64'd1);
      check("t6_refetch_addr", 64'(bus.mem_addr), 64'd0);
      repeat (5) tick();
      check("t6_valid", 64'(bus.inst_valid), 64'd1);
      check("t6_inst", 64'(bus.inst), 64'h8B1F03E0);
      check("t6_pc", bus.inst_pc, 64'd0);

      // Randomized traffic against a transaction-level model: each instruction starts at
      // age 0, reads PC+0..3 at ages 0..3 and is presented from age 5 until accepted.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      exp_pc = 64'd0;
      age = 0;
      for (int c = 0; c < 3000; c++) begin
         if (age < 4) begin
            ea = exp_pc[7:0] + 8'(age);
            check("rnd_rd_en", 64'(bus.mem_rd_en), 64'd1);
            check("rnd_addr", 64'(bus.mem_addr), 64'(ea));
         end else begin
            check("rnd_rd_idle", 64'(bus.mem_rd_en), 64'd0);
         end
         check("rnd_valid", 64'(bus.inst_valid), 64'(age >= 5));
         if (age >= 5) begin
            check("rnd_pc", bus.inst_pc, exp_pc);
            check("rnd_inst", 64'(bus.inst), 64'(word_at(exp_pc)));
         end
         check("rnd_fault", 64'(bus.fetch_fault), 64'd0);

         bus.inst_ready     = ($urandom % 3) != 0;
         bus.redirect_valid = ($urandom % 12) == 0;
         bus.redirect_pc    = pick_pc();

         if (bus.redirect_valid) begin
            exp_pc = bus.redirect_pc;
            age = 0;
         end else if ((age >= 5) && bus.inst_ready) begin
            exp_pc = exp_pc + 64'd4;
            age = 0;
         end else if (age < 5) begin
            age++;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
